// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 memory responder.
// LFSR constants are used only when L2_STALL_INJECT_EN is defined.
package l2_pkg;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_GRANT, WR_COMMIT} l2_state_e;

   localparam int          L2_WORD_W    = 32;
   localparam int          L2_BURST_LEN = 4;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;
   // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/l2_rr_arbiter.sv
// Two-port round-robin picker; rr_last remembers the previous winner.
module l2_rr_arbiter
   import l2_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   output logic       win,
   output logic       any
);

   logic rr_last;

   always_comb begin
      any = |req;
      if (rr_last) win = req[0] ? 1'b0 : 1'b1;
      else         win = req[1] ? 1'b1 : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)      rr_last <= 1'b1;
      else if (upd) rr_last <= win;
   end

endmodule

// File: rtl/l2_mem_responder.sv
// L2 responder serving L1 read bursts and single-word writes from a local array.
// Optional build macro L2_STALL_INJECT_EN adds LFSR-driven read-grant stalls.
module l2_mem_responder
   import l2_pkg::*;
#(
   parameter int L2_AW     = 10,
   parameter int BURST_LEN = L2_BURST_LEN,
   parameter int NPORTS    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        rd_en,
   input  logic [NPORTS-1:0]        wr_req,
   input  logic [NPORTS-1:0]        wr_en,
   input  logic [NPORTS-1:0][31:0]  addr,
   input  logic [NPORTS-1:0][31:0]  wr_data,
   output logic [NPORTS-1:0]        rd_granted,
   output logic [NPORTS-1:0]        wr_granted,
   output logic [L2_WORD_W-1:0]     rd_data,
   output logic                     wr_drop
);

   localparam int DEPTH = 1 << L2_AW;
   localparam int CW    = $clog2(BURST_LEN + 1);

   l2_state_e         state, state_nxt;
   logic              owner, owner_nxt;
   logic [CW-1:0]     beat_cnt, beat_nxt;
   logic              arb_win, arb_any, arb_upd;
   logic              stall;
   logic              rd_beat, mem_we;
   logic [L2_AW-1:0]  mem_idx;
   logic [L2_WORD_W-1:0] mem [DEPTH];

   // Upper address bits are deliberately ignored so addresses wrap on the array depth
   logic unused_addr_hi;
   assign unused_addr_hi = ^{addr[0][31:L2_AW], addr[1][31:L2_AW]};
   assign mem_idx        = addr[owner][L2_AW-1:0];

   l2_rr_arbiter u_arb (
      .clk (clk),
      .rst (rst),
      .req (rd_en | wr_req),
      .upd (arb_upd),
      .win (arb_win),
      .any (arb_any)
   );

`ifdef L2_STALL_INJECT_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_next(lfsr);
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      beat_nxt   = beat_cnt;
      arb_upd    = 1'b0;
      rd_granted = '0;
      wr_granted = '0;
      wr_drop    = 1'b0;
      rd_beat    = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               arb_upd   = 1'b1;
               owner_nxt = arb_win;
               beat_nxt  = '0;
               state_nxt = rd_en[arb_win] ? RD_BURST : WR_GRANT;
            end
         end
         RD_BURST: begin
            if (!rd_en[owner]) begin
               state_nxt = IDLE;
            end else if ((beat_cnt < CW'(BURST_LEN)) && !stall) begin
               rd_beat           = 1'b1;
               rd_granted[owner] = 1'b1;
               beat_nxt          = beat_cnt + CW'(1);
            end
         end
         WR_GRANT: begin
            wr_granted[owner] = 1'b1;
            state_nxt         = WR_COMMIT;
         end
         WR_COMMIT: begin
            mem_we    = wr_en[owner];
            wr_drop   = ~wr_en[owner];
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 1'b0;
         beat_cnt <= '0;
         rd_data  <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_nxt;
         if (rd_beat) rd_data <= mem[mem_idx];
      end
   end

   // A write caught by reset in its commit cycle is discarded
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[mem_idx] <= wr_data[owner];
   end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: directed protocol scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_l2_mem_responder;

   localparam int AW = 10;
`ifdef L2_STALL_INJECT_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       rd_en = '0, wr_req = '0, wr_en = '0;
   logic [1:0][31:0] addr = '0, wr_data = '0;
   logic [1:0]       rd_granted, wr_granted;
   logic [31:0]      rd_data;
   logic             wr_drop;

   int n_chk = 0;
   int n_err = 0;

   l2_mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_req     (wr_req),
      .wr_en      (wr_en),
      .addr       (addr),
      .wr_data    (wr_data),
      .rd_granted (rd_granted),
      .wr_granted (wr_granted),
      .rd_data    (rd_data),
      .wr_drop    (wr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: which transaction is in flight, and what the array holds
   int          m_kind = 0;      // 0 none, 1 read burst, 2 write grant, 3 write commit
   int          m_owner = 0;
   int          m_beats = 0;
   int          m_rr_last = 1;
   int          m_lfsr = 16'hACE1;
   logic [31:0] m_rd_data = '0;
   bit          m_rd_known = 1'b0;
   bit          m_started = 1'b0;
   logic [31:0] m_mem [int];

   always @(negedge clk) begin
      logic [1:0] e_rdg, e_wrg, rq;
      logic       e_drop;
      bit         stl;
      int         win, idx;
      e_rdg  = '0;
      e_wrg  = '0;
      e_drop = 1'b0;
      stl    = STALL_ON && ((m_lfsr & 1) == 1);
      idx    = int'(addr[m_owner][AW-1:0]);
      case (m_kind)
         1: if (rd_en[m_owner] && m_beats < 4 && !stl) e_rdg[m_owner] = 1'b1;
         2: e_wrg[m_owner] = 1'b1;
         3: e_drop = ~wr_en[m_owner];
         default: ;
      endcase
      if (m_started) begin
         chk("cyc_rd_granted", {30'b0, rd_granted}, {30'b0, e_rdg});
         chk("cyc_wr_granted", {30'b0, wr_granted}, {30'b0, e_wrg});
         chk("cyc_wr_drop", {31'b0, wr_drop}, {31'b0, e_drop});
         if (m_rd_known) chk("cyc_rd_data", rd_data, m_rd_data);
      end
      if (rst) begin
         m_kind = 0; m_beats = 0; m_rr_last = 1; m_lfsr = 16'hACE1;
         m_rd_data = '0; m_rd_known = 1'b1; m_started = 1'b1;
      end else begin
         case (m_kind)
            0: begin
               rq = rd_en | wr_req;
               if (rq != 2'b00) begin
                  if (rq == 2'b11) win = 1 - m_rr_last;
                  else             win = rq[0] ? 0 : 1;
                  m_rr_last = win;
                  m_owner   = win;
                  m_beats   = 0;
                  m_kind    = rd_en[win] ? 1 : 2;
               end
            end
            1: begin
               if (e_rdg != 2'b00) begin
                  m_rd_known = m_mem.exists(idx);
                  if (m_rd_known) m_rd_data = m_mem[idx];
                  m_beats++;
               end
               if (!rd_en[m_owner]) m_kind = 0;
            end
            2: m_kind = 3;
            3: begin
               if (wr_en[m_owner]) m_mem[idx] = wr_data[m_owner];
               m_kind = 0;
            end
            default: m_kind = 0;
         endcase
         m_lfsr = ((m_lfsr >> 1) | ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15)) & 16'hFFFF;
      end
   end

   logic [31:0] cap [2][4];

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d, input bit en);
      bit got;
      got = 1'b0;
      wr_req[p] = 1'b1;
      addr[p]   = a;
      for (int t = 0; t < 50 && !got; t++) begin
         @(posedge clk); #1;
         if (wr_granted[p]) got = 1'b1;
      end
      chk("wr_grant_seen", 32'(got), 32'd1);
      wr_req[p] = 1'b0;
      @(posedge clk); #1;
      wr_en[p]   = en;
      wr_data[p] = d;
      #1;
      chk("wr_grant_pulse", {30'b0, wr_granted}, 32'd0);
      chk("wr_drop_commit", {31'b0, wr_drop}, {31'b0, ~en});
      @(posedge clk); #1;
      wr_en[p] = 1'b0;
      chk("wr_drop_after", {31'b0, wr_drop}, 32'd0);
   endtask

   // Requester model: re-presents the next word address after each accepted beat
   task automatic do_reads(input logic [1:0] ports, input logic [31:0] b0, input logic [31:0] b1,
                           output int first, output int span);
      int cnt[2], hl[2];
      bit gl[2], done[2];
      logic [31:0] base[2];
      int firstc, lastc;
      base[0] = b0; base[1] = b1;
      first = -1; firstc = -1; lastc = -1;
      for (int p = 0; p < 2; p++) begin
         cnt[p] = 0; hl[p] = 0; gl[p] = 1'b0; done[p] = ~ports[p];
         if (ports[p]) begin rd_en[p] = 1'b1; addr[p] = base[p]; end
      end
      for (int cyc = 0; cyc < 300 && !(done[0] && done[1]); cyc++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (!done[p]) begin
               if (gl[p]) begin
                  if (cnt[p] < 4) cap[p][cnt[p]] = rd_data;
                  cnt[p]++;
                  addr[p] = base[p] + 32'(cnt[p]);
               end
               gl[p] = rd_granted[p];
               if (gl[p]) begin
                  if (first < 0) first = p;
                  if (firstc < 0) firstc = cyc;
                  lastc = cyc;
               end
               if (cnt[p] >= 4 && !gl[p]) begin
                  hl[p]++;
                  if (hl[p] > 2) begin rd_en[p] = 1'b0; done[p] = 1'b1; end
               end
            end
         end
      end
      chk("read_done", 32'(done[0] && done[1]), 32'd1);
      for (int p = 0; p < 2; p++) begin
         if (ports[p]) chk("burst_len", 32'(cnt[p]), 32'd4);
         rd_en[p] = 1'b0;
      end
      span = lastc - firstc + 1;
      @(posedge clk); #1;
   endtask

   initial begin
      int first, span, g;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_rd_granted", {30'b0, rd_granted}, 32'd0);
      chk("rst_wr_granted", {30'b0, wr_granted}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_wr_drop", {31'b0, wr_drop}, 32'd0);

      for (int i = 0; i < 16; i++) do_write(0, 32'h40 + 32'(i), 32'hA000_0040 + 32'(i), 1'b1);
      for (int i = 0; i < 4; i++)  do_write(0, 32'h10 + 32'(i), 32'hA000_0010 + 32'(i), 1'b1);

      do_reads(2'b10, 32'h0, 32'h40, first, span);
      for (int k = 0; k < 4; k++) chk("p1_burst_data", cap[1][k], 32'hA000_0040 + 32'(k));

      do_reset();
      do_reads(2'b11, 32'h44, 32'h48, first, span);
      chk("rr_first_after_reset", 32'(first), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("dual_p0_data", cap[0][k], 32'hA000_0044 + 32'(k));
         chk("dual_p1_data", cap[1][k], 32'hA000_0048 + 32'(k));
      end

      do_write(0, 32'h10, 32'hDEAD_BEEF, 1'b1);
      do_reads(2'b11, 32'h4C, 32'h40, first, span);
      chk("rr_first_after_p0", 32'(first), 32'd1);

      do_reads(2'b01, 32'h10, 32'h0, first, span);
      chk("write_readback", cap[0][0], 32'hDEAD_BEEF);
      chk("write_neighbour", cap[0][1], 32'hA000_0011);

      do_write(1, 32'h10, 32'h1234_5678, 1'b0);
      do_reads(2'b01, 32'h10, 32'h0, first, span);
      chk("drop_no_write", cap[0][0], 32'hDEAD_BEEF);

      do_reads(2'b10, 32'h0, 32'hFFFF_FC40, first, span);
      chk("addr_wrap", cap[1][0], 32'hA000_0040);

      // Reset in the middle of a burst
      rd_en[0] = 1'b1; addr[0] = 32'h40; g = 0;
      for (int t = 0; t < 50 && g < 2; t++) begin
         @(posedge clk); #1;
         if (rd_granted[0]) g++;
      end
      chk("midburst_beats", 32'(g), 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midburst_rst_grant", {30'b0, rd_granted}, 32'd0);
      chk("midburst_rst_data", rd_data, 32'd0);
      rst = 1'b0; rd_en[0] = 1'b0;
      @(posedge clk); #1;
      do_reads(2'b10, 32'h0, 32'h44, first, span);
      for (int k = 0; k < 4; k++) chk("post_rst_data", cap[1][k], 32'hA000_0044 + 32'(k));

      do_reset();
      do_reads(2'b01, 32'h40, 32'h0, first, span);
      for (int k = 0; k < 4; k++) chk("stall_burst_data", cap[0][k], 32'hA000_0040 + 32'(k));
      if (STALL_ON) chk("stall_span_gt4", 32'(span > 4), 32'd1);
      else          chk("burst_span", 32'(span), 32'd4);

      // Random traffic, including mid-burst drops, write drops and occasional resets
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 7) == 0) rd_en[p] = ~rd_en[p];
            wr_req[p]        = ($urandom_range(0, 3) == 0);
            wr_en[p]         = 1'($urandom_range(0, 1));
            addr[p][31:AW]   = (32 - AW)'($urandom);
            addr[p][AW-1:0]  = AW'(32'h40 + $urandom_range(0, 15));
            wr_data[p]       = $urandom;
         end
      end
      rst = 1'b0; rd_en = '0; wr_req = '0; wr_en = '0;
      repeat (4) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
